ep_bulk_in: RTL and testbench

Bulk IN end-point: the device-to-host counterpart of the bulk OUT end-point.
- Buffers frames from a bulk data source and splits them into USB packets of at most MAX_PACKET_LENGTH bytes.
- Supplies each packet to the USB/ULPI packet encoder when the controller selects this end-point.
- Retransmits on timeout, toggles DATA0/1 parity on ACK, and emits a ZDP when a frame length is an exact multiple of MAX_PACKET_LENGTH.

---
 rtl/ep_bulk_in.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_ep_bulk_in.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ep_bulk_in.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ep_bulk_in                                                   |
// | Description : USB bulk IN end-point. Buffers frames from an AXI-Stream     |
// |               byte source, splits them into packets of at most             |
// |               MAX_PACKET_LENGTH bytes and streams each packet to the       |
// |               packet encoder when the controller selects this end-point.   |
// |               Handles retransmission on timeout, DATA0/1 toggling on ACK   |
// |               and zero-length packets after frames that are an exact       |
// |               multiple of MAX_PACKET_LENGTH.                               |
// | Ports       : clock/reset            system clock, sync active-high reset  |
// |               set_conf_i/clr_conf_i  configure (clear, go IDLE) / halt     |
// |               selected_i             IN token addressed to this end-point  |
// |               ack_recv_i/timedout_i  handshake outcome for last packet     |
// |               ep_ready_o             a packet (data or ZDP) is available   |
// |               stalled_o/parity_o     halted / current DATA PID parity      |
// |               s_t*                   AXI-S byte input from data source     |
// |               m_t*                   AXI-S byte output to packet encoder   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ep_bulk_in #(
  parameter int MAX_PACKET_LENGTH = 512,
  parameter int PACKET_FIFO_DEPTH = 2048,
  parameter int ENABLED           = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       set_conf_i,
  input  logic       clr_conf_i,
  input  logic       selected_i,
  input  logic       ack_recv_i,
  input  logic       timedout_i,
  output logic       ep_ready_o,
  output logic       stalled_o,
  output logic       parity_o,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tlast,
  input  logic [7:0] s_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tkeep,
  output logic       m_tlast,
  output logic [7:0] m_tdata
);

  localparam int AW = $clog2(PACKET_FIFO_DEPTH);
  localparam int CW = $clog2(MAX_PACKET_LENGTH);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_PACKET_LENGTH - 1);
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(PACKET_FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_IDLE = 2'd1,
    ST_SEND = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Pointers carry an extra MSB so that full and empty are distinguishable.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cmt_ptr_q, cmt_ptr_d;     // first byte not yet acknowledged
  logic [AW:0]   spec_ptr_q, spec_ptr_d;   // first byte not yet accepted by encoder
  logic [AW:0]   rd_addr_q, rd_addr_d;     // RAM prefetch address (runs ahead)
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;   // frame byte count modulo packet size
  logic [AW:0]   chunks_q, chunks_d;
  logic          zdp_pend_q, zdp_pend_d;
  logic          parity_q, parity_d;
  logic          ep_ready_q, ep_ready_d;
  logic          is_zdp_q, is_zdp_d;       // packet in flight is a ZDP
  logic          last_zdp_q, last_zdp_d;   // zdp_after bit of last sent byte

  // Read pipeline: RAM output register followed by the AXI-S output register.
  logic          ram_vld_q, ram_vld_d;
  logic [9:0]    ram_q;
  logic          m_tvalid_q, m_tvalid_d;
  logic          m_tkeep_q, m_tkeep_d;
  logic          m_tlast_q, m_tlast_d;
  logic [7:0]    m_tdata_q, m_tdata_d;
  logic          m_zdp_q, m_zdp_d;

  logic [9:0]    mem [PACKET_FIFO_DEPTH];

  logic [AW:0]   level;
  logic          wr_en;
  logic          chunk_full;
  logic          wr_end;
  logic          wr_zdp;
  logic          chunk_dec;
  logic          has_pkt;
  logic          advance;
  logic          beat_acc;
  logic          issue;

  assign level      = wr_ptr_q - cmt_ptr_q;
  assign s_tready   = (level < DEPTH_W);
  assign wr_en      = s_tvalid && s_tready;
  assign chunk_full = (byte_cnt_q == CNT_LAST);
  assign wr_end     = s_tlast || chunk_full;
  assign wr_zdp     = s_tlast && chunk_full;
  assign has_pkt    = (chunks_q != '0) || zdp_pend_q;

  assign advance    = !m_tvalid_q || m_tready;
  assign beat_acc   = m_tvalid_q && m_tready;
  // A new RAM read is issued whenever the RAM register is empty or drains into
  // the output register this cycle, so the stream has no bubbles.
  assign issue      = (state_q == ST_SEND) && (!ram_vld_q || advance);

  assign ep_ready_o = ep_ready_q;
  assign stalled_o  = (state_q == ST_HALT);
  assign parity_o   = parity_q;
  assign m_tvalid   = m_tvalid_q;
  assign m_tkeep    = m_tkeep_q;
  assign m_tlast    = m_tlast_q;
  assign m_tdata    = m_tdata_q;

  // Control path: FSM, pointers, chunk/ZDP bookkeeping.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    cmt_ptr_d  = cmt_ptr_q;
    spec_ptr_d = spec_ptr_q;
    rd_addr_d  = rd_addr_q;
    byte_cnt_d = byte_cnt_q;
    zdp_pend_d = zdp_pend_q;
    parity_d   = parity_q;
    is_zdp_d   = is_zdp_q;
    last_zdp_d = last_zdp_q;
    chunk_dec  = 1'b0;

    if (wr_en) begin
      wr_ptr_d   = wr_ptr_q + PTR_ONE;
      byte_cnt_d = s_tlast ? '0 : byte_cnt_q + CNT_ONE;
    end

    case (state_q)
      ST_HALT: begin
        state_d = ST_HALT;
      end
      ST_IDLE: begin
        if (selected_i && has_pkt) begin
          state_d    = ST_SEND;
          spec_ptr_d = cmt_ptr_q;
          rd_addr_d  = cmt_ptr_q;
          is_zdp_d   = zdp_pend_q;   // a pending ZDP goes before new data
        end
      end
      ST_SEND: begin
        if (!selected_i) begin
          state_d    = ST_IDLE;
          spec_ptr_d = cmt_ptr_q;
        end else begin
          if (issue) begin
            rd_addr_d = rd_addr_q + PTR_ONE;
          end
          if (beat_acc && m_tkeep_q) begin
            spec_ptr_d = spec_ptr_q + PTR_ONE;
          end
          if (beat_acc && m_tlast_q) begin
            state_d    = ST_WAIT;
            last_zdp_d = m_zdp_q;
          end
        end
      end
      ST_WAIT: begin
        if (ack_recv_i) begin
          state_d   = ST_IDLE;
          cmt_ptr_d = spec_ptr_q;
          parity_d  = !parity_q;
          if (is_zdp_q) begin
            zdp_pend_d = 1'b0;
          end else begin
            chunk_dec  = 1'b1;
            zdp_pend_d = last_zdp_q;
          end
        end else if (timedout_i) begin
          state_d    = ST_IDLE;
          spec_ptr_d = cmt_ptr_q;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase

    if (clr_conf_i) begin
      state_d    = ST_HALT;
      spec_ptr_d = cmt_ptr_q;
    end

    chunks_d = chunks_q + {{AW{1'b0}}, (wr_en && wr_end)} - {{AW{1'b0}}, chunk_dec};

    if (set_conf_i) begin
      state_d    = clr_conf_i ? ST_HALT : ST_IDLE;
      wr_ptr_d   = '0;
      cmt_ptr_d  = '0;
      spec_ptr_d = '0;
      rd_addr_d  = '0;
      byte_cnt_d = '0;
      chunks_d   = '0;
      zdp_pend_d = 1'b0;
      parity_d   = 1'b0;
    end

    if (ENABLED == 0) begin
      state_d = ST_HALT;
    end

    ep_ready_d = (state_d == ST_IDLE) && ((chunks_d != '0) || zdp_pend_d);
  end

  // Data path: RAM register -> output register, flushed whenever SEND ends.
  always_comb begin
    ram_vld_d  = 1'b0;
    m_tvalid_d = 1'b0;
    m_tkeep_d  = m_tkeep_q;
    m_tlast_d  = m_tlast_q;
    m_tdata_d  = m_tdata_q;
    m_zdp_d    = m_zdp_q;
    if ((state_q == ST_SEND) && (state_d == ST_SEND)) begin
      ram_vld_d  = ram_vld_q || issue;
      m_tvalid_d = m_tvalid_q;
      if (advance) begin
        m_tvalid_d = ram_vld_q;
        if (is_zdp_q) begin
          m_tkeep_d = 1'b0;
          m_tlast_d = 1'b1;
          m_tdata_d = 8'h00;
          m_zdp_d   = 1'b0;
        end else begin
          m_tkeep_d = 1'b1;
          m_tlast_d = ram_q[8];
          m_tdata_d = ram_q[7:0];
          m_zdp_d   = ram_q[9];
        end
      end
    end
  end

  // Packet buffer: {zdp_after, end, data}.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= {wr_zdp, wr_end, s_tdata};
    end
    if (issue) begin
      ram_q <= mem[rd_addr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_HALT;
      wr_ptr_q   <= '0;
      cmt_ptr_q  <= '0;
      spec_ptr_q <= '0;
      rd_addr_q  <= '0;
      byte_cnt_q <= '0;
      chunks_q   <= '0;
      zdp_pend_q <= 1'b0;
      parity_q   <= 1'b0;
      ep_ready_q <= 1'b0;
      is_zdp_q   <= 1'b0;
      last_zdp_q <= 1'b0;
      ram_vld_q  <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tkeep_q  <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= 8'h00;
      m_zdp_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      cmt_ptr_q  <= cmt_ptr_d;
      spec_ptr_q <= spec_ptr_d;
      rd_addr_q  <= rd_addr_d;
      byte_cnt_q <= byte_cnt_d;
      chunks_q   <= chunks_d;
      zdp_pend_q <= zdp_pend_d;
      parity_q   <= parity_d;
      ep_ready_q <= ep_ready_d;
      is_zdp_q   <= is_zdp_d;
      last_zdp_q <= last_zdp_d;
      ram_vld_q  <= ram_vld_d;
      m_tvalid_q <= m_tvalid_d;
      m_tkeep_q  <= m_tkeep_d;
      m_tlast_q  <= m_tlast_d;
      m_tdata_q  <= m_tdata_d;
      m_zdp_q    <= m_zdp_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ep_bulk_in.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ep_bulk_in                                                |
// | Description : Self-checking bench for ep_bulk_in. Keeps a packet-level     |
// |               reference (byte queue plus packet-length queue, 0 = ZDP)     |
// |               and compares every streamed beat and status output.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ep_bulk_in;

  localparam int MPL   = 512;
  localparam int DEPTH = 2048;

  logic       clock = 1'b0;
  logic       reset;
  logic       set_conf_i, clr_conf_i, selected_i, ack_recv_i, timedout_i;
  logic       ep_ready_o, stalled_o, parity_o;
  logic       s_tvalid, s_tready, s_tlast;
  logic [7:0] s_tdata;
  logic       m_tvalid, m_tready, m_tkeep, m_tlast;
  logic [7:0] m_tdata;

  int checks = 0;
  int errors = 0;

  // Reference: unacknowledged bytes in order, and the packets they form.
  logic [7:0] pbytes[$];
  int         pkt_len[$];
  logic       exp_parity = 1'b0;

  ep_bulk_in #(
    .MAX_PACKET_LENGTH(MPL),
    .PACKET_FIFO_DEPTH(DEPTH),
    .ENABLED(1)
  ) dut (
    .clock(clock), .reset(reset),
    .set_conf_i(set_conf_i), .clr_conf_i(clr_conf_i), .selected_i(selected_i),
    .ack_recv_i(ack_recv_i), .timedout_i(timedout_i),
    .ep_ready_o(ep_ready_o), .stalled_o(stalled_o), .parity_o(parity_o),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tdata(m_tdata)
  );

  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one frame of n random bytes; the model splits it into packets.
  task automatic write_frame(input int n);
    int         guard;
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b        = 8'($urandom);
      s_tvalid = 1'b1;
      s_tdata  = b;
      s_tlast  = (i == n - 1);
      guard    = 0;
      while (!s_tready && guard < 5000) begin
        tick();
        guard++;
      end
      if (guard >= 5000) chk("s_tready_stuck", {31'd0, s_tready}, 32'd1);
      tick();
      pbytes.push_back(b);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    for (int k = 0; k < n / MPL; k++) pkt_len.push_back(MPL);
    pkt_len.push_back(n % MPL);   // a remainder of 0 means a trailing ZDP
  endtask

  // One IN transaction for the head packet of the model.
  task automatic do_in(input bit rand_rdy);
    int len, nb, idx, guard;
    bit done, prev_acc, r;
    len = pkt_len[0];
    nb  = (len == 0) ? 1 : len;
    chk("in_parity", {31'd0, parity_o}, {31'd0, exp_parity});
    chk("in_ready", {31'd0, ep_ready_o}, 32'd1);
    selected_i = 1'b1;
    m_tready   = 1'b0;
    tick(); chk("lat_c1", {31'd0, m_tvalid}, 32'd0);
    tick(); chk("lat_c2", {31'd0, m_tvalid}, 32'd0);
    tick(); chk("lat_c3", {31'd0, m_tvalid}, 32'd1);
    idx = 0; done = 1'b0; guard = 0; prev_acc = 1'b0;
    while (!done && guard < 20000) begin
      if (prev_acc) chk("no_gap", {31'd0, m_tvalid}, 32'd1);
      r        = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      m_tready = r;
      prev_acc = 1'b0;
      if (m_tvalid && r) begin
        chk("data", {24'd0, m_tdata}, (len == 0) ? 32'd0 : {24'd0, pbytes[idx]});
        chk("keep", {31'd0, m_tkeep}, (len != 0) ? 32'd1 : 32'd0);
        chk("last", {31'd0, m_tlast}, (idx == nb - 1) ? 32'd1 : 32'd0);
        idx++;
        done     = (idx == nb);
        prev_acc = 1'b1;
      end
      tick();
      guard++;
    end
    if (!done) chk("in_beats", idx, nb);
    m_tready   = 1'b0;
    selected_i = 1'b0;
    chk("wait_valid", {31'd0, m_tvalid}, 32'd0);
    chk("wait_ready", {31'd0, ep_ready_o}, 32'd0);
  endtask

  task automatic do_ack(input bit with_tmo);
    int len;
    ack_recv_i = 1'b1;
    timedout_i = with_tmo;
    tick();
    ack_recv_i = 1'b0;
    timedout_i = 1'b0;
    len = pkt_len.pop_front();
    repeat (len) void'(pbytes.pop_front());
    exp_parity = ~exp_parity;
    chk("ack_parity", {31'd0, parity_o}, {31'd0, exp_parity});
    chk("ack_ready", {31'd0, ep_ready_o}, (pkt_len.size() != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic do_tmo();
    timedout_i = 1'b1;
    tick();
    timedout_i = 1'b0;
    chk("tmo_parity", {31'd0, parity_o}, {31'd0, exp_parity});
    chk("tmo_ready", {31'd0, ep_ready_o}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; set_conf_i = 1'b0; clr_conf_i = 1'b0; selected_i = 1'b0;
    ack_recv_i = 1'b0; timedout_i = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tdata = 8'h00; m_tready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_stalled", {31'd0, stalled_o}, 32'd1);
    chk("rst_ready", {31'd0, ep_ready_o}, 32'd0);
    chk("rst_mvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_stready", {31'd0, s_tready}, 32'd1);
    chk("rst_parity", {31'd0, parity_o}, 32'd0);
    set_conf_i = 1'b1; tick(); set_conf_i = 1'b0;
    chk("conf_stalled", {31'd0, stalled_o}, 32'd0);

    // 100-byte frame
    write_frame(100);
    do_in(1'b0);
    do_ack(1'b0);

    // 1024-byte frame: two full packets then a ZDP
    write_frame(1024);
    do_in(1'b0); do_ack(1'b0);
    do_in(1'b0); do_ack(1'b0);
    chk("zdp_len", pkt_len[0], 0);
    do_in(1'b0); do_ack(1'b0);

    // 600-byte frame with a timeout on the first packet
    write_frame(600);
    do_in(1'b0); do_tmo();
    do_in(1'b0); do_ack(1'b0);
    do_in(1'b0); do_ack(1'b0);

    // IN on an empty buffer
    selected_i = 1'b1;
    repeat (6) begin
      tick();
      chk("empty_mvalid", {31'd0, m_tvalid}, 32'd0);
    end
    selected_i = 1'b0;
    chk("empty_stalled", {31'd0, stalled_o}, 32'd0);
    chk("empty_parity", {31'd0, parity_o}, {31'd0, exp_parity});

    // Fill the buffer completely, then free one packet
    write_frame(DEPTH);
    chk("full_stready", {31'd0, s_tready}, 32'd0);
    do_in(1'b0); do_ack(1'b0);
    chk("freed_stready", {31'd0, s_tready}, 32'd1);

    // clr_conf mid-SEND, then set_conf
    selected_i = 1'b1;
    m_tready   = 1'b1;
    repeat (8) tick();
    clr_conf_i = 1'b1; tick(); clr_conf_i = 1'b0;
    chk("clr_stalled", {31'd0, stalled_o}, 32'd1);
    chk("clr_mvalid", {31'd0, m_tvalid}, 32'd0);
    selected_i = 1'b0;
    m_tready   = 1'b0;
    tick();
    chk("halt_ready", {31'd0, ep_ready_o}, 32'd0);
    chk("halt_stalled", {31'd0, stalled_o}, 32'd1);
    set_conf_i = 1'b1; tick(); set_conf_i = 1'b0;
    pbytes.delete(); pkt_len.delete(); exp_parity = 1'b0;
    chk("set_stalled", {31'd0, stalled_o}, 32'd0);
    chk("set_parity", {31'd0, parity_o}, 32'd0);
    chk("set_ready", {31'd0, ep_ready_o}, 32'd0);
    chk("set_stready", {31'd0, s_tready}, 32'd1);

    // 512-byte frame with a randomly stalling consumer, ZDP acked with timeout
    write_frame(MPL);
    do_in(1'b1); do_ack(1'b0);
    do_in(1'b1); do_ack(1'b1);

    // Randomised traffic
    for (int it = 0; it < 14; it++) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? MPL * int'($urandom_range(1, 2))
                                      : int'($urandom_range(1, 1100));
      if (pbytes.size() + n <= DEPTH) write_frame(n);
      chk("rnd_ready", {31'd0, ep_ready_o}, (pkt_len.size() != 0) ? 32'd1 : 32'd0);
      repeat ($urandom_range(1, 3)) begin
        if (pkt_len.size() != 0) begin
          do_in(1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) do_tmo();
          else do_ack(1'($urandom_range(0, 1)));
        end
      end
    end
    while (pkt_len.size() != 0) begin
      do_in(1'b0);
      do_ack(1'b0);
    end
    chk("end_ready", {31'd0, ep_ready_o}, 32'd0);
    chk("end_stready", {31'd0, s_tready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
